// File: rtl/cpu64_div_ctrl.sv
// Execute-stage front end for an unsigned divide core: operand sign handling, RISC-V
// divide-by-zero / overflow special cases, result sign fix-up and a valid/ready result port.
module cpu64_div_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [1:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o,
    output logic            core_req_o,
    output logic [XLEN-1:0] core_a_o,
    output logic [XLEN-1:0] core_b_o,
    input  logic [XLEN-1:0] core_q_i,
    input  logic [XLEN-1:0] core_r_i,
    input  logic            core_done_i
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } state_t;

    // Bits above the low word; empty when XLEN==32
    localparam logic [XLEN-1:0] HI_MASK  = ~XLEN'(32'hFFFF_FFFF);
    localparam logic [XLEN-1:0] MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_WORD = HI_MASK | XLEN'(32'h8000_0000);

    function automatic logic [XLEN-1:0] extend_word(input logic [XLEN-1:0] v, input logic fill);
        return fill ? (v | HI_MASK) : (v & ~HI_MASK);
    endfunction

    function automatic logic [XLEN-1:0] negate_if(input logic [XLEN-1:0] v, input logic neg);
        logic signed [XLEN-1:0] s;
        s = $signed(v);
        return neg ? $unsigned(-s) : v;
    endfunction

    state_t state, state_next;

    logic            word_op, signed_op, rem_op;
    logic [XLEN-1:0] a_ext, b_ext, min_val;
    logic            neg_a, neg_b;
    logic            div_zero, overflow, special;
    logic [XLEN-1:0] special_raw, special_res;
    logic [XLEN-1:0] mag_a, mag_b;

    logic            neg_q_r, neg_r_r, rem_r, word_r;
    logic [XLEN-1:0] fix_raw, fix_res;
    logic            accept, capture;

    // Operand preparation for the op currently offered
    always_comb begin
        word_op   = (XLEN == 64) && word_i;
        signed_op = !op_i[0];
        rem_op    = op_i[1];

        a_ext = word_op ? extend_word(op_a_i, signed_op & op_a_i[31]) : op_a_i;
        b_ext = word_op ? extend_word(op_b_i, signed_op & op_b_i[31]) : op_b_i;

        neg_a = signed_op & a_ext[XLEN-1];
        neg_b = signed_op & b_ext[XLEN-1];
        mag_a = negate_if(a_ext, neg_a);
        mag_b = negate_if(b_ext, neg_b);

        min_val  = word_op ? MIN_WORD : MIN_FULL;
        div_zero = (b_ext == '0);
        overflow = signed_op && (a_ext == min_val) && (b_ext == '1);
        special  = div_zero || overflow;

        if (div_zero) begin
            special_raw = rem_op ? a_ext : '1;
        end else begin
            special_raw = rem_op ? '0 : a_ext;
        end
        special_res = word_op ? extend_word(special_raw, special_raw[31]) : special_raw;
    end

    // Sign fix-up of the core result, using flags captured at accept
    always_comb begin
        fix_raw = rem_r ? negate_if(core_r_i, neg_r_r) : negate_if(core_q_i, neg_q_r);
        fix_res = word_r ? extend_word(fix_raw, fix_raw[31]) : fix_raw;
    end

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        capture     = 1'b0;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        core_req_o  = 1'b0;
        busy_o      = 1'b1;
        case (state)
            IDLE: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b0;
                if (in_valid_i && !flush_i) begin
                    accept     = 1'b1;
                    state_next = special ? RESP : ISSUE;
                end
            end
            ISSUE, WAIT: begin
                core_req_o = (state == ISSUE);
                // An issued core op cannot be killed, so a flush must drain its done
                if (flush_i) begin
                    state_next = core_done_i ? IDLE : DRAIN;
                end else if (core_done_i) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end else begin
                    state_next = WAIT;
                end
            end
            RESP: begin
                out_valid_o = 1'b1;
                if (flush_i || out_ready_i) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (core_done_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            result_o <= '0;
            core_a_o <= '0;
            core_b_o <= '0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            rem_r    <= 1'b0;
            word_r   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                core_a_o <= mag_a;
                core_b_o <= mag_b;
                neg_q_r  <= neg_a ^ neg_b;
                neg_r_r  <= neg_a;
                rem_r    <= rem_op;
                word_r   <= word_op;
                if (special) begin
                    result_o <= special_res;
                end
            end
            if (capture) begin
                result_o <= fix_res;
            end
        end
    end

endmodule

// File: tb/tb_cpu64_div_ctrl.sv
// Directed bench for cpu64_div_ctrl with a simple behavioural divide core of selectable latency.
module tb_cpu64_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, word, flush, out_valid, out_ready, busy;
    logic        core_req, core_done;
    logic [1:0]  op;
    logic [63:0] op_a, op_b, result, core_a, core_b, core_q, core_r;

    always #5 clk = ~clk;

    cpu64_div_ctrl #(.XLEN(64)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .op_i       (op),
        .word_i     (word),
        .op_a_i     (op_a),
        .op_b_i     (op_b),
        .flush_i    (flush),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o   (result),
        .busy_o     (busy),
        .core_req_o (core_req),
        .core_a_o   (core_a),
        .core_b_o   (core_b),
        .core_q_i   (core_q),
        .core_r_i   (core_r),
        .core_done_i(core_done)
    );

    // Behavioural core: lat==0 answers in the request cycle, else lat cycles after it
    int          lat = 2;
    int          cnt = 0;
    int          req_count = 0;
    logic        force_done = 1'b0;
    logic [63:0] mq = '0, mr = '0;

    always @(posedge clk) begin
        if (core_req) req_count <= req_count + 1;
        if (core_req && lat > 0) begin
            cnt <= lat;
            mq  <= core_a / core_b;
            mr  <= core_a % core_b;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
        end
    end

    assign core_done = (lat == 0 && core_req) || (cnt == 1) || force_done;
    assign core_q = (lat == 0) ? ((core_b == '0) ? '0 : core_a / core_b) : mq;
    assign core_r = (lat == 0) ? ((core_b == '0) ? '0 : core_a % core_b) : mr;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic w, input logic [63:0] a, input logic [63:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("issue_ready", {63'd0, in_ready}, 64'd1);
        op = o; word = w; op_a = a; op_b = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("resp_seen", {63'd0, out_valid}, 64'd1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("consume_ready", {63'd0, in_ready}, 64'd1);
        chk("consume_valid", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        int n;
        int rc;
        int spurious;
        rst_n = 1'b0; in_valid = 1'b0; word = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op = 2'b00; op_a = '0; op_b = '0;

        #3;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_core_req", {63'd0, core_req}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_core_a", core_a, 64'd0);
        chk("rst_core_b", core_b, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // DIV -7 / 2
        issue(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        chk("div_core_req", {63'd0, core_req}, 64'd1);
        chk("div_core_a", core_a, 64'd7);
        chk("div_core_b", core_b, 64'd2);
        chk("div_busy", {63'd0, busy}, 64'd1);
        chk("div_in_ready", {63'd0, in_ready}, 64'd0);
        wait_resp(n);
        chk("div_latency", n, 64'd3);
        chk("div_result", result, 64'hFFFF_FFFF_FFFF_FFFD);
        consume();

        // REM -7 % 2
        issue(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        wait_resp(n);
        chk("rem_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        consume();

        // DIV / REM 20 by -3
        issue(2'b00, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("div_neg_b_core_b", core_b, 64'd3);
        wait_resp(n);
        chk("div_neg_b_result", result, 64'hFFFF_FFFF_FFFF_FFFA);
        consume();
        issue(2'b10, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD);
        wait_resp(n);
        chk("rem_neg_b_result", result, 64'd2);
        consume();

        // Special cases bypass the core
        rc = req_count;
        issue(2'b01, 1'b0, 64'd5, 64'd0);
        chk("divu0_valid", {63'd0, out_valid}, 64'd1);
        chk("divu0_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("divu0_core_req", {63'd0, core_req}, 64'd0);
        consume();
        issue(2'b11, 1'b0, 64'd9, 64'd0);
        chk("remu0_result", result, 64'd9);
        consume();
        issue(2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("div_ovf_result", result, 64'h8000_0000_0000_0000);
        consume();
        issue(2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rem_ovf_result", result, 64'd0);
        consume();
        issue(2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF);
        chk("divw_ovf_result", result, 64'hFFFF_FFFF_8000_0000);
        consume();
        issue(2'b10, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF);
        chk("remw_ovf_result", result, 64'd0);
        consume();
        chk("special_no_req", req_count, rc);

        // REMUW through a zero-stage core
        lat = 0;
        issue(2'b11, 1'b1, 64'h0000_0001_FFFF_FFFF, 64'h10);
        chk("remuw_core_a", core_a, 64'h0000_0000_FFFF_FFFF);
        chk("remuw_core_b", core_b, 64'h10);
        wait_resp(n);
        chk("remuw_latency", n, 64'd1);
        chk("remuw_result", result, 64'h0000_0000_0000_000F);
        consume();

        // Flush in ISSUE with done in the same cycle goes straight to IDLE
        issue(2'b01, 1'b0, 64'd10, 64'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_issue_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_issue_valid", {63'd0, out_valid}, 64'd0);

        // Flush in WAIT drains the stale done
        lat = 5;
        issue(2'b01, 1'b0, 64'd50, 64'd5);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("drain_in_ready", {63'd0, in_ready}, 64'd0);
        chk("drain_busy", {63'd0, busy}, 64'd1);
        n = 0;
        spurious = 0;
        while (!in_ready && n < 20) begin
            if (out_valid) spurious++;
            tick();
            n++;
        end
        chk("drain_length", n, 64'd4);
        chk("drain_spurious", spurious, 64'd0);

        lat = 2;
        issue(2'b01, 1'b0, 64'd100, 64'd7);
        wait_resp(n);
        chk("divu_after_drain", result, 64'd14);

        // Back-pressure holds the result
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_result", result, 64'd14);
        end
        consume();

        // Flush in RESP drops the result
        issue(2'b01, 1'b0, 64'd1, 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_resp_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_resp_ready", {63'd0, in_ready}, 64'd1);

        // Flush in IDLE wins over in_valid
        op = 2'b01; word = 1'b0; op_a = 64'd1; op_b = 64'd0;
        in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_busy", {63'd0, busy}, 64'd0);
        chk("flush_idle_valid", {63'd0, out_valid}, 64'd0);

        // Stale done in IDLE is ignored
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        chk("stale_done_valid", {63'd0, out_valid}, 64'd0);
        chk("stale_done_ready", {63'd0, in_ready}, 64'd1);

        // Asynchronous reset mid-operation
        lat = 5;
        issue(2'b01, 1'b0, 64'd50, 64'd5);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_result", result, 64'd0);
        chk("midrst_core_a", core_a, 64'd0);
        tick();
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) spurious++;
        end
        chk("midrst_stale_done", spurious, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
